vga_sync_monitor: RTL

//  Receive-side VGA timing monitor for the CHIP-8 display path. Samples the
//  VGA_CLK/HS/VS/BLANK_n/RGB stream a timing generator drives, recovers pixel

---
 rtl/vga_sync_monitor_if.sv | 22 ++
 rtl/vga_sync_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_monitor_if
// Brief   : VGA pixel stream bundle (pixel clock, syncs, blank, RGB).
// Revision: 1.0 - initial release
// ============================================================================
interface vga_sync_monitor_if;
    logic        vga_clk;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [23:0] vga_rgb;

    modport master (
        output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_rgb
    );

    modport slave (
        input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_rgb
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_monitor.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_monitor
// Brief   : Receive-side VGA timing monitor: pixel coordinates, geometry
//           measurement, lock tracking and per-frame RGB checksum.
// Revision: 1.0 - initial release
// ============================================================================
module vga_sync_monitor #(
    parameter int H_TOTAL   = 800,
    parameter int H_ACTIVE  = 640,
    parameter int V_TOTAL   = 525,
    parameter int V_ACTIVE  = 480,
    parameter int WDOG_BITS = 16
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    vga_sync_monitor_if.slave   vga,
    output logic                pix_valid,
    output logic [9:0]          pix_x,
    output logic [9:0]          pix_y,
    output logic [23:0]         pix_rgb,
    output logic                frame_done,
    output logic                locked,
    output logic [10:0]         meas_htotal,
    output logic [9:0]          meas_hactive,
    output logic [9:0]          meas_vtotal,
    output logic [9:0]          meas_vactive,
    output logic [31:0]         frame_sum,
    output logic [7:0]          err_count
);

    localparam logic [10:0] c_H_TOTAL  = 11'(H_TOTAL);
    localparam logic [9:0]  c_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0]  c_V_TOTAL  = 10'(V_TOTAL);
    localparam logic [9:0]  c_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [10:0] c_HCNT_MAX = 11'h7FF;

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic                 r_clk_q, r_clk_qq;
    logic                 r_hs_q, r_vs_q, r_blank_q;
    logic [23:0]          r_rgb_q;
    logic                 r_hs_p, r_vs_p, r_blank_p;
    logic [10:0]          r_hcnt;
    logic [9:0]           r_vcnt, r_acnt, r_arow;
    logic [31:0]          r_sum;
    logic [WDOG_BITS-1:0] r_wdog;
    logic [1:0]           r_state, w_state_nxt;

    logic w_strobe, w_hs_fall, w_vs_fall, w_blank_fall;
    logic w_hcnt_sat, w_wdog_trip, w_force_search, w_geom_ok, w_lock_lost;

    // Edges compare the value seen at this strobe with the one from the previous strobe
    assign w_strobe       = r_clk_q & ~r_clk_qq;
    assign w_hs_fall      = w_strobe & r_hs_p & ~r_hs_q;
    assign w_vs_fall      = w_strobe & r_vs_p & ~r_vs_q;
    assign w_blank_fall   = w_strobe & r_blank_p & ~r_blank_q;
    assign w_hcnt_sat     = (r_hcnt == c_HCNT_MAX);
    assign w_wdog_trip    = (r_wdog == {WDOG_BITS{1'b1}});
    assign w_force_search = w_hcnt_sat | w_wdog_trip;
    assign w_geom_ok      = (meas_htotal == c_H_TOTAL) && (meas_hactive == c_H_ACTIVE) &&
                            (r_vcnt == c_V_TOTAL) && (r_arow == c_V_ACTIVE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_force_search) begin
            w_state_nxt = S_SEARCH;
        end else if (w_vs_fall) begin
            case (r_state)
                S_SEARCH:  w_state_nxt = S_MEASURE;
                S_MEASURE: w_state_nxt = w_geom_ok ? S_LOCKED : S_MEASURE;
                S_LOCKED:  w_state_nxt = w_geom_ok ? S_LOCKED : S_MEASURE;
                default:   w_state_nxt = S_SEARCH;
            endcase
        end
    end

    always_comb begin
        locked      = (r_state == S_LOCKED);
        w_lock_lost = w_vs_fall && (r_state == S_LOCKED) && !w_geom_ok && !w_force_search;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_q      <= 1'b0;
            r_clk_qq     <= 1'b0;
            r_hs_q       <= 1'b0;
            r_vs_q       <= 1'b0;
            r_blank_q    <= 1'b0;
            r_rgb_q      <= '0;
            r_hs_p       <= 1'b0;
            r_vs_p       <= 1'b0;
            r_blank_p    <= 1'b0;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_acnt       <= '0;
            r_arow       <= '0;
            r_sum        <= '0;
            r_wdog       <= '0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_rgb      <= '0;
            frame_done   <= 1'b0;
            meas_htotal  <= '0;
            meas_hactive <= '0;
            meas_vtotal  <= '0;
            meas_vactive <= '0;
            frame_sum    <= '0;
            err_count    <= '0;
        end else begin
            r_clk_q    <= vga.vga_clk;
            r_clk_qq   <= r_clk_q;
            r_hs_q     <= vga.vga_hs;
            r_vs_q     <= vga.vga_vs;
            r_blank_q  <= vga.vga_blank_n;
            r_rgb_q    <= vga.vga_rgb;
            pix_valid  <= w_strobe & r_blank_q;
            frame_done <= w_vs_fall;

            if (w_strobe) begin
                r_wdog <= '0;
            end else if (!w_wdog_trip) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_lock_lost && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            // Later blocks override earlier ones: blank_fall, hs_fall, then vs_fall
            if (w_strobe) begin
                r_hs_p    <= r_hs_q;
                r_vs_p    <= r_vs_q;
                r_blank_p <= r_blank_q;

                if (r_blank_q) begin
                    pix_x   <= r_acnt;
                    pix_y   <= r_arow;
                    pix_rgb <= r_rgb_q;
                    r_acnt  <= r_acnt + 10'd1;
                    r_sum   <= r_sum + {8'd0, r_rgb_q};
                end

                if (w_blank_fall) begin
                    meas_hactive <= r_acnt;
                    r_acnt       <= '0;
                    r_arow       <= r_arow + 10'd1;
                end

                if (w_hs_fall) begin
                    meas_htotal <= w_hcnt_sat ? c_HCNT_MAX : r_hcnt + 11'd1;
                    r_hcnt      <= '0;
                    r_vcnt      <= r_vcnt + 10'd1;
                end else if (!w_hcnt_sat) begin
                    r_hcnt <= r_hcnt + 11'd1;
                end

                if (w_vs_fall) begin
                    meas_vtotal  <= r_vcnt;
                    meas_vactive <= r_arow;
                    frame_sum    <= r_sum;
                    r_vcnt       <= '0;
                    r_arow       <= '0;
                    r_sum        <= '0;
                end
            end

            // A stalled pixel clock leaves the line counter frozen, so restart it here
            if (w_wdog_trip) begin
                r_hcnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
